// File: rtl/sram_phase_sequencer_pkg.sv
// Shared types and codes for the decode-flow phase sequencer and its SRAM owner mux.
package sram_phase_sequencer_pkg;

  typedef enum logic [3:0] {
    S_SEQ_VGA  = 4'd0,
    S_GAP_UART = 4'd1,
    S_SEQ_UART = 4'd2,
    S_GAP_M2   = 4'd3,
    S_SEQ_M2   = 4'd4,
    S_GAP_M1   = 4'd5,
    S_SEQ_M1   = 4'd6,
    S_GAP_VGA  = 4'd7,
    S_SEQ_ERR  = 4'd8
  } seq_state_type;

  localparam logic [2:0] OWN_NONE = 3'd0;
  localparam logic [2:0] OWN_VGA  = 3'd1;
  localparam logic [2:0] OWN_UART = 3'd2;
  localparam logic [2:0] OWN_M2   = 3'd3;
  localparam logic [2:0] OWN_M1   = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_M2   = 2'b01;
  localparam logic [1:0] ERR_M1   = 2'b10;

  localparam int WDOG_LIMIT_DEFAULT = 32'd49999999;

endpackage

// File: rtl/sram_phase_sequencer_owner_mux.sv
// Combinational SRAM bus select driven by the registered owner code.
module sram_owner_mux
  import sram_phase_sequencer_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic [2:0]        owner,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              uart_we_n,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [DATA_W-1:0] m2_wdata,
  input  logic              m2_we_n,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we_n,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_we_n
);

  // Route the selected requester; idle/unknown owners park the bus read-only at 0.
  always_comb begin
    sram_address    = '0;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (owner)
      OWN_UART: begin
        sram_address    = uart_addr;
        sram_write_data = uart_wdata;
        sram_we_n       = uart_we_n;
      end
      OWN_M2: begin
        sram_address    = m2_addr;
        sram_write_data = m2_wdata;
        sram_we_n       = m2_we_n;
      end
      OWN_M1: begin
        sram_address    = m1_addr;
        sram_write_data = m1_wdata;
        sram_we_n       = m1_we_n;
      end
      OWN_VGA: begin
        sram_address    = vga_addr;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
      end
      default: begin
        sram_address    = '0;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Decode-flow sequencer: UART load -> M2 -> M1 -> VGA, owning the single SRAM port
// with a one-cycle dead gap on every ownership change and a per-phase watchdog.
module sram_phase_sequencer
  import sram_phase_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int WDOG_W     = 26,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Uart_req,
  input  logic              Uart_done,
  input  logic              M2_done,
  input  logic              M1_done,
  output logic              M2_go,
  output logic              M1_start,
  output logic              Uart_enable,
  output logic              VGA_enable,
  input  logic [ADDR_W-1:0] UART_addr,
  input  logic [DATA_W-1:0] UART_wdata,
  input  logic              UART_we_n,
  input  logic [ADDR_W-1:0] M2_addr,
  input  logic [DATA_W-1:0] M2_wdata,
  input  logic              M2_we_n,
  input  logic [ADDR_W-1:0] M1_addr,
  input  logic [DATA_W-1:0] M1_wdata,
  input  logic              M1_we_n,
  input  logic [ADDR_W-1:0] VGA_addr,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic [2:0]        Owner,
  output logic              Error,
  output logic [1:0]        Err_phase,
  output logic [7:0]        Frames_done
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

  seq_state_type     state_r, state_s;
  logic [2:0]        owner_r, owner_s;
  logic              m2_go_r, m2_go_s, m1_start_r, m1_start_s;
  logic              uart_en_r, uart_en_s, vga_en_r, vga_en_s;
  logic              error_r, error_s;
  logic [1:0]        err_phase_r, err_phase_s;
  logic [7:0]        frames_r, frames_s;
  logic [WDOG_W-1:0] wdog_r, wdog_s;

  // Next-state logic; done/req inputs only matter in the state that owns them.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_SEQ_VGA:  if (Uart_req)  state_s = S_GAP_UART; else state_s = S_SEQ_VGA;
      S_GAP_UART: state_s = S_SEQ_UART;
      S_SEQ_UART: if (Uart_done) state_s = S_GAP_M2;   else state_s = S_SEQ_UART;
      S_GAP_M2:   state_s = S_SEQ_M2;
      S_SEQ_M2: begin
        if (M2_done)                 state_s = S_GAP_M1;
        else if (wdog_r == WDOG_MAX) state_s = S_SEQ_ERR;
        else                         state_s = S_SEQ_M2;
      end
      S_GAP_M1:   state_s = S_SEQ_M1;
      S_SEQ_M1: begin
        if (M1_done)                 state_s = S_GAP_VGA;
        else if (wdog_r == WDOG_MAX) state_s = S_SEQ_ERR;
        else                         state_s = S_SEQ_M1;
      end
      S_GAP_VGA:  state_s = S_SEQ_VGA;
      S_SEQ_ERR:  if (Uart_req)  state_s = S_GAP_UART; else state_s = S_SEQ_ERR;
      default:    state_s = S_SEQ_VGA;
    endcase
  end

  // Registered-output targets decoded from the upcoming state; gaps and ERR own nothing.
  always_comb begin
    owner_s    = OWN_NONE;
    m2_go_s    = 1'b0;
    m1_start_s = 1'b0;
    uart_en_s  = 1'b0;
    vga_en_s   = 1'b0;
    case (state_s)
      S_SEQ_VGA:  begin owner_s = OWN_VGA;  vga_en_s   = 1'b1; end
      S_SEQ_UART: begin owner_s = OWN_UART; uart_en_s  = 1'b1; end
      S_SEQ_M2:   begin owner_s = OWN_M2;   m2_go_s    = 1'b1; end
      S_SEQ_M1:   begin owner_s = OWN_M1;   m1_start_s = 1'b1; end
      default:    owner_s = OWN_NONE;
    endcase

    error_s = (state_s == S_SEQ_ERR);
    if (state_s != S_SEQ_ERR)       err_phase_s = ERR_NONE;
    else if (state_r == S_SEQ_M2)   err_phase_s = ERR_M2;
    else if (state_r == S_SEQ_M1)   err_phase_s = ERR_M1;
    else                            err_phase_s = err_phase_r;

    // Watchdog restarts at 0 on every phase entry.
    if ((state_s == S_SEQ_M2 || state_s == S_SEQ_M1) && state_s == state_r)
      wdog_s = wdog_r + WDOG_ONE;
    else
      wdog_s = '0;

    if (state_r == S_SEQ_M1 && M1_done) frames_s = frames_r + 8'd1;
    else                                frames_s = frames_r;
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= S_SEQ_VGA;
      owner_r     <= OWN_VGA;
      m2_go_r     <= 1'b0;
      m1_start_r  <= 1'b0;
      uart_en_r   <= 1'b0;
      vga_en_r    <= 1'b1;
      error_r     <= 1'b0;
      err_phase_r <= ERR_NONE;
      frames_r    <= 8'd0;
      wdog_r      <= '0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      m2_go_r     <= m2_go_s;
      m1_start_r  <= m1_start_s;
      uart_en_r   <= uart_en_s;
      vga_en_r    <= vga_en_s;
      error_r     <= error_s;
      err_phase_r <= err_phase_s;
      frames_r    <= frames_s;
      wdog_r      <= wdog_s;
    end
  end

  assign Owner       = owner_r;
  assign M2_go       = m2_go_r;
  assign M1_start    = m1_start_r;
  assign Uart_enable = uart_en_r;
  assign VGA_enable  = vga_en_r;
  assign Error       = error_r;
  assign Err_phase   = err_phase_r;
  assign Frames_done = frames_r;

  sram_owner_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .owner           (owner_r),
    .uart_addr       (UART_addr),
    .uart_wdata      (UART_wdata),
    .uart_we_n       (UART_we_n),
    .m2_addr         (M2_addr),
    .m2_wdata        (M2_wdata),
    .m2_we_n         (M2_we_n),
    .m1_addr         (M1_addr),
    .m1_wdata        (M1_wdata),
    .m1_we_n         (M1_we_n),
    .vga_addr        (VGA_addr),
    .sram_address    (SRAM_address),
    .sram_write_data (SRAM_write_data),
    .sram_we_n       (SRAM_we_n)
  );

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Self-checking bench: vector table through a scoreboard queue, plus hand-written
// watchdog, done-at-limit, frame-wrap and asynchronous-reset sequences.
module tb_sram_phase_sequencer;

  localparam int WL = 100;
  localparam logic [17:0] UA = 18'h00011, M2A = 18'h01234, M1A = 18'h00033, VA = 18'h00044;
  localparam logic [15:0] UD = 16'hA1A1, M2D = 16'hB2B2, M1D = 16'hC3C3;

  logic        Clock = 1'b0, Resetn = 1'b0;
  logic        Uart_req = 1'b0, Uart_done = 1'b0, M2_done = 1'b0, M1_done = 1'b0;
  logic        M2_go, M1_start, Uart_enable, VGA_enable, SRAM_we_n, Error;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic [2:0]  Owner;
  logic [1:0]  Err_phase;
  logic [7:0]  Frames_done;

  logic [17:0] UART_addr = UA, M2_addr = M2A, M1_addr = M1A, VGA_addr = VA;
  logic [15:0] UART_wdata = UD, M2_wdata = M2D, M1_wdata = M1D;
  logic        UART_we_n = 1'b0, M2_we_n = 1'b0, M1_we_n = 1'b0;

  sram_phase_sequencer #(.ADDR_W(18), .DATA_W(16), .WDOG_W(26), .WDOG_LIMIT(WL)) dut (
    .Clock(Clock), .Resetn(Resetn), .Uart_req(Uart_req), .Uart_done(Uart_done),
    .M2_done(M2_done), .M1_done(M1_done), .M2_go(M2_go), .M1_start(M1_start),
    .Uart_enable(Uart_enable), .VGA_enable(VGA_enable),
    .UART_addr(UART_addr), .UART_wdata(UART_wdata), .UART_we_n(UART_we_n),
    .M2_addr(M2_addr), .M2_wdata(M2_wdata), .M2_we_n(M2_we_n),
    .M1_addr(M1_addr), .M1_wdata(M1_wdata), .M1_we_n(M1_we_n),
    .VGA_addr(VGA_addr), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Owner(Owner), .Error(Error), .Err_phase(Err_phase),
    .Frames_done(Frames_done)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       req, udone, m2d, m1d;
    logic [2:0] owner;
    logic       go2, go1, uen, ven, err;
    logic [1:0] eph;
    logic [7:0] frames;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Expected SRAM bus {addr, wdata, we_n} for an owner code.
  function automatic logic [34:0] bus_for(input logic [2:0] own);
    case (own)
      3'd1:    return {VA, 16'h0000, 1'b1};
      3'd2:    return {UA, UD, 1'b0};
      3'd3:    return {M2A, M2D, 1'b0};
      3'd4:    return {M1A, M1D, 1'b0};
      default: return {18'h00000, 16'h0000, 1'b1};
    endcase
  endfunction

  task automatic add(input logic req, udone, m2d, m1d, input logic [2:0] own,
                     input logic go2, go1, uen, ven, input logic [7:0] fr);
    vec_t v;
    v = '{req, udone, m2d, m1d, own, go2, go1, uen, ven, 1'b0, 2'b00, fr};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    logic [52:0] act, req;
    Uart_req = v.req; Uart_done = v.udone; M2_done = v.m2d; M1_done = v.m1d;
    exp_q.push_back(v);
    cyc();
    e   = exp_q.pop_front();
    act = {Owner, M2_go, M1_start, Uart_enable, VGA_enable, Error, Err_phase, Frames_done,
           SRAM_address, SRAM_write_data, SRAM_we_n};
    req = {e.owner, e.go2, e.go1, e.uen, e.ven, e.err, e.eph, e.frames, bus_for(e.owner)};
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL vec%0d: got %0h expected %0h", idx, act, req);
    end
  endtask

  task automatic do_reset();
    Uart_req = 1'b0; Uart_done = 1'b0; M2_done = 1'b0; M1_done = 1'b0;
    Resetn = 1'b0;
    repeat (2) cyc();
    chk("rst_state", {Owner, M2_go, M1_start, Uart_enable, VGA_enable, Error, Err_phase, Frames_done},
        {3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0});
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // Drive VGA/ERR -> ... -> first cycle of S_SEQ_M2.
  task automatic to_m2();
    Uart_req = 1'b1; cyc(); Uart_req = 1'b0; cyc();
    Uart_done = 1'b1; cyc(); Uart_done = 1'b0; cyc();
  endtask

  task automatic run_frame();
    to_m2();
    M2_done = 1'b1; cyc(); M2_done = 1'b0; cyc();
    M1_done = 1'b1; cyc(); M1_done = 1'b0; cyc();
  endtask

  initial begin
    int n;
    // req ud m2d m1d owner go2 go1 uen ven frames
    add(0,0,0,0, 3'd1, 0,0,0,1, 8'd0);
    add(1,0,0,0, 3'd0, 0,0,0,0, 8'd0);
    add(1,0,0,0, 3'd2, 0,0,1,0, 8'd0);
    add(0,0,0,1, 3'd2, 0,0,1,0, 8'd0);
    add(0,0,1,0, 3'd2, 0,0,1,0, 8'd0);
    add(0,1,0,0, 3'd0, 0,0,0,0, 8'd0);
    add(0,0,1,0, 3'd3, 1,0,0,0, 8'd0);
    add(1,1,0,0, 3'd3, 1,0,0,0, 8'd0);
    add(0,0,0,1, 3'd3, 1,0,0,0, 8'd0);
    add(0,0,1,0, 3'd0, 0,0,0,0, 8'd0);
    add(0,0,1,0, 3'd4, 0,1,0,0, 8'd0);
    add(1,0,1,0, 3'd4, 0,1,0,0, 8'd0);
    add(0,0,0,1, 3'd0, 0,0,0,0, 8'd1);
    add(0,1,0,1, 3'd1, 0,0,0,1, 8'd1);
    add(0,0,0,0, 3'd1, 0,0,0,1, 8'd1);
    add(1,0,0,0, 3'd0, 0,0,0,0, 8'd1);
    add(0,0,0,0, 3'd2, 0,0,1,0, 8'd1);
    add(0,1,0,0, 3'd0, 0,0,0,0, 8'd1);
    add(0,0,1,0, 3'd3, 1,0,0,0, 8'd1);
    add(0,0,1,0, 3'd0, 0,0,0,0, 8'd1);
    add(0,0,0,1, 3'd4, 0,1,0,0, 8'd1);
    add(0,0,0,1, 3'd0, 0,0,0,0, 8'd2);
    add(0,0,0,0, 3'd1, 0,0,0,1, 8'd2);

    do_reset();
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // M2 watchdog: go stays high for WL+1 cycles (wdog 0..WL) then ERR.
    do_reset();
    #1;
    to_m2();
    n = 0;
    while (M2_go === 1'b1 && n < 3 * WL) begin n++; cyc(); end
    chk("m2_wdog_cycles", n, WL + 1);
    chk("m2_err", {Error, Err_phase, M2_go, Owner}, {1'b1, 2'b01, 1'b0, 3'd0});
    Uart_done = 1'b1; M2_done = 1'b1; cyc(); Uart_done = 1'b0; M2_done = 1'b0;
    chk("err_sticky", {Error, Err_phase, Owner}, {1'b1, 2'b01, 3'd0});
    Uart_req = 1'b1; cyc(); Uart_req = 1'b0;
    chk("err_clear_gap", {Error, Err_phase, Owner}, {1'b0, 2'b00, 3'd0});
    cyc();
    chk("err_to_uart", {Owner, Uart_enable}, {3'd2, 1'b1});

    // M1 watchdog.
    Uart_done = 1'b1; cyc(); Uart_done = 1'b0; cyc();
    M2_done = 1'b1; cyc(); M2_done = 1'b0; cyc();
    chk("m1_entry", {Owner, M1_start}, {3'd4, 1'b1});
    n = 0;
    while (M1_start === 1'b1 && n < 3 * WL) begin n++; cyc(); end
    chk("m1_wdog_cycles", n, WL + 1);
    chk("m1_err", {Error, Err_phase, M1_start, Owner, Frames_done}, {1'b1, 2'b10, 1'b0, 3'd0, 8'd0});

    // Done in the same cycle as the limit wins.
    to_m2();
    repeat (WL) cyc();
    chk("m2_at_limit", {M2_go, Error}, {1'b1, 1'b0});
    M2_done = 1'b1; cyc(); M2_done = 1'b0;
    chk("m2_done_wins", {Owner, Error, M2_go}, {3'd0, 1'b0, 1'b0});
    cyc();
    chk("m1_after_limit", {Owner, M1_start}, {3'd4, 1'b1});
    repeat (WL) cyc();
    M1_done = 1'b1; cyc(); M1_done = 1'b0;
    chk("m1_done_wins", {Owner, Error, Frames_done}, {3'd0, 1'b0, 8'd1});
    cyc();
    chk("vga_back", {Owner, VGA_enable}, {3'd1, 1'b1});

    // Frame counter wrap.
    do_reset();
    #1;
    repeat (255) run_frame();
    chk("frames_255", {Owner, Frames_done}, {3'd1, 8'd255});
    run_frame();
    chk("frames_wrap", {Owner, Frames_done}, {3'd1, 8'd0});

    // Asynchronous reset in the middle of M1.
    to_m2();
    M2_done = 1'b1; cyc(); M2_done = 1'b0; cyc();
    chk("pre_async_m1", {Owner, M1_start}, {3'd4, 1'b1});
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_rst", {Owner, M1_start, VGA_enable, SRAM_address, SRAM_we_n},
        {3'd1, 1'b0, 1'b1, VA, 1'b1});
    @(negedge Clock);
    Resetn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_phase_sequencer.md
Name: sram_phase_sequencer

Overview:
Top-level controller that runs the decode flow: UART load, then Milestone 2 (IDCT), then Milestone 1 (upsample/CSC), then VGA display. It owns the single SRAM port and routes it to exactly one requester per phase, with a one-cycle dead gap on every ownership change. It also drives the go/start handshakes, a per-phase watchdog and status outputs. It replaces the ad-hoc top FSM and SRAM mux in the top module.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
WDOG_W, 26, watchdog counter width
WDOG_LIMIT, 49999999, max cycles per M2/M1 phase (1 s at 50 MHz)

Ports:
Clock  in  1  50 MHz system clock
Resetn  in  1  asynchronous active-low reset
Uart_req  in  1  level; UART load requested (RX activity or PB0)
Uart_done  in  1  1-cycle pulse; UART timeout, load finished
M2_done  in  1  Milestone 2 finished (level or pulse)
M1_done  in  1  Milestone 1 finished (level or pulse)
M2_go  out  1  start/hold for Milestone 2
M1_start  out  1  start/hold for Milestone 1
Uart_enable  out  1  UART owns SRAM; enable receiver
VGA_enable  out  1  VGA owns SRAM
UART_addr, UART_wdata, UART_we_n  in  ADDR_W/DATA_W/1  UART requester bus
M2_addr, M2_wdata, M2_we_n  in  ADDR_W/DATA_W/1  M2 requester bus
M1_addr, M1_wdata, M1_we_n  in  ADDR_W/DATA_W/1  M1 requester bus
VGA_addr  in  ADDR_W  VGA read address
SRAM_address  out  ADDR_W  to SRAM controller
SRAM_write_data  out  DATA_W  to SRAM controller
SRAM_we_n  out  1  to SRAM controller
Owner  out  3  current owner code
Error  out  1  sticky watchdog error
Err_phase  out  2  01=M2 timeout, 10=M1 timeout, 00=none
Frames_done  out  8  completed decodes, wraps 255->0

Behaviour:
- Reset: state S_SEQ_VGA, Owner=OWN_VGA, VGA_enable=1, all go/start/enable=0, Error=0, Err_phase=0, Frames_done=0, watchdog=0.
- Owner codes: NONE=0, VGA=1, UART=2, M2=3, M1=4. Owner is a register; the SRAM mux is combinational from Owner.
- Mux: UART/M2/M1 pass addr/wdata/we_n. VGA passes VGA_addr with we_n=1 and wdata=0. NONE drives addr=0, wdata=0, we_n=1.
- States and transitions:
  - S_SEQ_VGA -> S_GAP_UART on Uart_req.
  - S_GAP_UART -> S_SEQ_UART after exactly 1 cycle, Owner=NONE.
  - S_SEQ_UART -> S_GAP_M2 on Uart_done. Uart_enable=1 throughout S_SEQ_UART.
  - S_GAP_M2 -> S_SEQ_M2.
  - S_SEQ_M2 -> S_GAP_M1 on M2_done.
  - S_GAP_M1 -> S_SEQ_M1.
  - S_SEQ_M1 -> S_GAP_VGA on M1_done. Frames_done increments on this edge.
  - S_GAP_VGA -> S_SEQ_VGA.
  - S_SEQ_ERR -> S_GAP_UART on Uart_req.
- Outputs are registered. Entering S_SEQ_M2 sets Owner=M2 and M2_go=1 on the same edge. M2_go holds high until M2_done is sampled high, then is low the next cycle. M1_start follows the same rule.
- Done is sampled only in its own phase. M2_done/M1_done high in any other state is ignored, including a stale level held from the prior frame.
- Watchdog: cleared on entry to S_SEQ_M2/S_SEQ_M1 and increments each cycle in those states. If watchdog == WDOG_LIMIT and done is not high that cycle: go to S_SEQ_ERR, Owner=NONE, go/start=0, Error=1, Err_phase set. Done high in the same cycle as the limit wins; no error.
- Error and Err_phase are cleared only by reset or by leaving S_SEQ_ERR.
- Uart_req is ignored in S_SEQ_UART, S_SEQ_M2, S_SEQ_M1 and all gap states. A new load only preempts VGA or ERR.
- Uart_done outside S_SEQ_UART is ignored.
- Reset mid-phase: asynchronous return to the reset values above. The SRAM bus immediately carries VGA owner values.

Decomposition:
- Shared package (alongside define_state.h): seq_state_type enum, owner code localparams, Err_phase codes, WDOG_LIMIT default.
- One natural sub-module: sram_owner_mux (combinational 5-way bus select on Owner). The FSM, watchdog and counters stay in the parent.

Test Plan:
1. Reset, then pulse Uart_req, wait 5 cycles, pulse Uart_done -> Owner sequence 1,0,2,…,2,0,3; M2_go rises on the cycle Owner=3.
2. Assert M2_done 20 cycles into M2 -> M2_go low next cycle; one cycle Owner=0; M1_start=1 with Owner=4. Then M1_done -> Owner 0 then 1, VGA_enable=1, Frames_done=1.
3. Gap check: set M2_we_n=0, M2_addr=18'h1234 during S_GAP_M2 -> SRAM_we_n=1, SRAM_address=0.
4. WDOG_LIMIT=100, M2_done never asserted -> at cycle 100 of the phase: Error=1, Err_phase=01, M2_go=0, Owner=0. Then Uart_req -> Error=0, Owner=2 after the gap.
5. Hold M2_done=1 across the whole M1 phase and assert Uart_req during M2 -> M2 phase exits immediately (stale-done rule only blocks other phases); Uart_req causes no change; frame completes normally.
6. 256 full frames -> Frames_done wraps to 0. Deassert Resetn mid-M1 -> M1_start=0, Owner=1 asynchronously.
